// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } ifu_state_t;

   localparam logic [1:0] F_NONE     = 2'd0;
   localparam logic [1:0] F_BUS      = 2'd1;
   localparam logic [1:0] F_MISALIGN = 2'd2;
   localparam logic [1:0] F_TIMEOUT  = 2'd3;

   localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ifu_timer.sv
// 16-bit saturating wait counter with clear/enable and a TIMEOUT-1 expiry compare.
module ifu_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [15:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 16'd1;
      end
   end

   assign expired = (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: registered PC, valid/ready request/response to instruction memory,
// one instruction at a time presented to decode.
module ifu_fetch
   import ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [1:0]  inst_fault,
   input  logic [31:0] next_pc,
   output logic [31:0] pc
);

   ifu_state_t  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] ipc_q, ipc_d;
   logic [1:0]  fault_q, fault_d;
   logic        misaligned;
   logic        expired;

   assign misaligned = (pc_q[1:0] != 2'b00);

   // Timer is held clear outside WAIT, so it always starts from zero on entry.
   ifu_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != WAIT),
      .en      (state_q == WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         ipc_q   <= '0;
         fault_q <= F_NONE;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      fault_d = fault_q;
      case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (misaligned) begin
               state_d = HOLD;
               inst_d  = '0;
               ipc_d   = pc_q;
               fault_d = F_MISALIGN;
            end else if (imem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // A response arriving on the expiry cycle takes priority over the timeout.
            if (imem_rsp_valid) begin
               state_d = HOLD;
               inst_d  = imem_rsp_err ? '0 : imem_rsp_data;
               ipc_d   = pc_q;
               fault_d = imem_rsp_err ? F_BUS : F_NONE;
            end else if (expired) begin
               state_d = HOLD;
               inst_d  = '0;
               ipc_d   = pc_q;
               fault_d = F_TIMEOUT;
            end
         end
         HOLD: begin
            if (inst_ready) begin
               state_d = REQ;
               pc_d    = next_pc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign imem_req_valid = (state_q == REQ) && !misaligned;
   assign imem_req_addr  = (state_q == REQ) ? pc_q : '0;
   assign imem_rsp_ready = (state_q == WAIT);
   assign inst_valid     = (state_q == HOLD);
   assign inst           = inst_q;
   assign inst_pc        = ipc_q;
   assign inst_fault     = fault_q;
   assign pc             = pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios plus randomized fetches
// checked cycle by cycle against a transaction-level expectation.
module tb_ifu_fetch;

   localparam logic [31:0] RST_PC = 32'h8000_0000;
   localparam int          TO     = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic        imem_rsp_ready;
   logic [31:0] imem_rsp_data = '0;
   logic        imem_rsp_err = 1'b0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  inst_fault;
   logic [31:0] next_pc = '0;
   logic [31:0] pc;

   int n_checks = 0;
   int n_fail   = 0;

   ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(TO)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_ready (imem_rsp_ready),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .next_pc        (next_pc),
      .pc             (pc)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   // One fetch transaction starting at a negedge in REQ. The expected presentation
   // comes from the fetch rules: misaligned -> fault 2; response within TO wait
   // cycles -> data or bus error; otherwise timeout after TO wait cycles.
   // rq: cycles of req backpressure, rp: wait cycle (1-based) carrying the response,
   // hd: cycles of inst backpressure, nx: next_pc supplied at the handshake.
   task automatic run_fetch(input logic [31:0] a, input int rq, input int rp,
                            input logic e, input logic [31:0] d, input int hd,
                            input logic [31:0] nx);
      logic [1:0]  xf;
      logic [31:0] xi;
      int          wmax;
      if (a[1:0] != 2'b00) begin
         xf = 2'd2; xi = '0;
      end else if (rp <= TO) begin
         xf = e ? 2'd1 : 2'd0; xi = e ? 32'd0 : d;
      end else begin
         xf = 2'd3; xi = '0;
      end
      if (a[1:0] != 2'b00) begin
         n_checks++;
         if (imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0 || pc !== a) begin
            n_fail++;
            $display("FAIL misalign_req: req_valid=%b rsp_ready=%b inst_valid=%b pc=%h, required 0 0 0 %h",
                     imem_req_valid, imem_rsp_ready, inst_valid, pc, a);
         end
         imem_rsp_valid = 1'($urandom);
         imem_rsp_data  = $urandom;
         @(negedge clk);
      end else begin
         for (int k = 0; k <= rq; k++) begin
            n_checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== a || pc !== a ||
                inst_valid !== 1'b0 || imem_rsp_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL req_phase[%0d]: req_valid=%b addr=%h pc=%h inst_valid=%b rsp_ready=%b, required 1 %h %h 0 0",
                        k, imem_req_valid, imem_req_addr, pc, inst_valid, imem_rsp_ready, a, a);
            end
            imem_req_ready = (k == rq);
            imem_rsp_valid = 1'($urandom);
            imem_rsp_err   = 1'($urandom);
            imem_rsp_data  = $urandom;
            @(negedge clk);
         end
         imem_req_ready = 1'b0;
         wmax = (rp <= TO) ? rp : TO;
         for (int w = 1; w <= wmax; w++) begin
            n_checks++;
            if (imem_rsp_ready !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL wait_phase[%0d]: rsp_ready=%b req_valid=%b inst_valid=%b, required 1 0 0",
                        w, imem_rsp_ready, imem_req_valid, inst_valid);
            end
            imem_rsp_valid = (w == rp);
            imem_rsp_data  = (w == rp) ? d : $urandom;
            imem_rsp_err   = (w == rp) ? e : 1'b0;
            @(negedge clk);
         end
      end
      for (int h = 0; h <= hd; h++) begin
         n_checks++;
         if (inst_valid !== 1'b1 || inst !== xi || inst_pc !== a || inst_fault !== xf ||
             imem_req_valid !== 1'b0 || imem_rsp_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_phase[%0d]: valid=%b inst=%h pc=%h fault=%0d req_valid=%b rsp_ready=%b, required 1 %h %h %0d 0 0",
                     h, inst_valid, inst, inst_pc, inst_fault, imem_req_valid, imem_rsp_ready, xi, a, xf);
         end
         inst_ready     = (h == hd);
         next_pc        = (h == hd) ? nx : $urandom;
         imem_rsp_valid = 1'($urandom);
         imem_rsp_err   = 1'($urandom);
         imem_rsp_data  = $urandom;
         @(negedge clk);
      end
      inst_ready     = 1'b0;
      imem_rsp_valid = 1'b0;
      n_checks++;
      if (pc !== nx || inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL next_pc: pc=%h inst_valid=%b, required %h 0", pc, inst_valid, nx);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         imem_req_ready = 1'($urandom);
         imem_rsp_valid = 1'($urandom);
         imem_rsp_err   = 1'($urandom);
         imem_rsp_data  = $urandom;
         inst_ready     = 1'($urandom);
         next_pc        = $urandom;
         @(negedge clk);
         n_checks++;
         if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'd0 || imem_rsp_ready !== 1'b0 ||
             inst_valid !== 1'b0 || inst !== 32'd0 || inst_pc !== 32'd0 || inst_fault !== 2'd0 ||
             pc !== RST_PC) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: reqv=%b addr=%h rspr=%b iv=%b inst=%h ipc=%h f=%0d pc=%h, required zeros and pc=%h",
                     i, imem_req_valid, imem_req_addr, imem_rsp_ready, inst_valid, inst, inst_pc,
                     inst_fault, pc, RST_PC);
         end
      end
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0; inst_ready = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_release: req_valid=%b, required 0", imem_req_valid);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_wait();
      run_fetch(RST_PC, 0, 1, 1'b0, 32'h0000_0413, 0, RST_PC + 32'd4);
      run_fetch(RST_PC + 32'd4, 0, 1, 1'b0, 32'h0041_0113, 0, RST_PC);
   endtask

   task automatic test_backpressure();
      run_fetch(RST_PC, 5, 2, 1'b0, 32'h1234_5678, 4, 32'h8000_0006);
   endtask

   task automatic test_misaligned();
      run_fetch(32'h8000_0006, 0, 1, 1'b0, 32'd0, 1, 32'h8000_0008);
   endtask

   task automatic test_bus_error_timeout();
      run_fetch(32'h8000_0008, 1, 3, 1'b1, 32'hDEAD_BEEF, 0, 32'h8000_000C);
      run_fetch(32'h8000_000C, 0, TO + 1, 1'b0, 32'hCAFE_F00D, 0, 32'h8000_0010);
      run_fetch(32'h8000_0010, 0, TO, 1'b0, 32'h0BAD_C0DE, 0, 32'h8000_0014);
      run_fetch(32'h8000_0014, 2, TO, 1'b1, 32'h5555_AAAA, 1, 32'h8000_0018);
   endtask

   task automatic test_random();
      logic [31:0] a, nx;
      a = 32'h8000_0018;
      for (int i = 0; i < 40; i++) begin
         nx = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) nx[1:0] = 2'($urandom_range(1, 3));
         run_fetch(a, $urandom_range(0, 3), $urandom_range(1, TO + 2),
                   ($urandom_range(0, 4) == 0), $urandom, $urandom_range(0, 3), nx);
         a = nx;
      end
      run_fetch(a, 0, 1, 1'b0, 32'h0000_0013, 0, 32'h0000_1000);
   endtask

   task automatic test_reset_mid_wait();
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      n_checks++;
      if (imem_rsp_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_wait_entry: rsp_ready=%b, required 1", imem_rsp_ready);
      end
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (imem_rsp_ready !== 1'b0 || imem_req_valid !== 1'b0 || pc !== RST_PC || inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_wait_reset: rsp_ready=%b req_valid=%b pc=%h inst_valid=%b, required 0 0 %h 0",
                  imem_rsp_ready, imem_req_valid, pc, inst_valid, RST_PC);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_wait_idle: req_valid=%b, required 0", imem_req_valid);
      end
      @(negedge clk);
      run_fetch(RST_PC, 0, 1, 1'b0, 32'h0000_0093, 0, RST_PC + 32'd4);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_misaligned();
      test_bus_error_timeout();
      test_random();
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
